// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2) datapath types, sizes and Karatsuba recombination
// Contents:
//   state_t        : sequencer states of the time-shared Karatsuba multiplier
//   W_DEF, H_DEF   : default operand width and half width
//   REC_MAX        : width of the recombination scratch vector (covers W up to 64)
//   kara_recombine : z0 ^ ((zm^z0^z2) << h) ^ (z2 << 2h), all carry-less
package gf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int W_DEF   = 32;
    localparam int H_DEF   = W_DEF / 2;
    localparam int REC_MAX = 128;

    // Callers zero-extend their partial products into REC_MAX bits and
    // slice the low 2W-1 bits of the result. That lets one function serve
    // every Karatsuba level regardless of its operand width.
    function automatic logic [REC_MAX-1:0] kara_recombine(
        input logic [REC_MAX-1:0] z0,
        input logic [REC_MAX-1:0] zm,
        input logic [REC_MAX-1:0] z2,
        input int unsigned        h
    );
        logic [REC_MAX-1:0] mid;
        mid = zm ^ z0 ^ z2;
        return z0 ^ (mid << h) ^ (z2 << (2 * h));
    endfunction

endpackage

// File: rtl/clmul16.sv
// rtl/clmul16.sv - combinational H x H carry-less multiplier (AND/XOR array)
// Ports:
//   x : input  [H-1:0]   multiplicand, bit i = coefficient of x^i
//   y : input  [H-1:0]   multiplier
//   z : output [2H-2:0]  carry-less product x*y
module clmul16
    import gf_pkg::*;
#(
    parameter int H = H_DEF
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-2:0] z
);

    localparam int ZW = 2 * H - 1;

    // Each set bit of y contributes a shifted copy of x; XOR is GF(2) addition.
    always_comb begin
        z = '0;
        for (int i = 0; i < H; i++) begin
            if (y[i]) begin
                z = z ^ (ZW'(x) << i);
            end
        end
    end

endmodule

// File: rtl/clmul_kara_seq.sv
// rtl/clmul_kara_seq.sv - sequential W x W carry-less multiplier, three Karatsuba passes on one H x H core
// Ports:
//   clk       : input         rising-edge clock
//   rst       : input         asynchronous active-high reset
//   in_valid  : input         operand pair valid
//   in_ready  : output        block can accept operands (state IDLE)
//   a, b      : input  [W-1]  operands, bit i = coefficient of x^i
//   out_valid : output        product valid (state DONE)
//   out_ready : input         consumer accepts product
//   p         : output [2W-2] carry-less product a*b
//   busy      : output        high in any state other than IDLE
module clmul_kara_seq
    import gf_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] p,
    output logic           busy
);

    localparam int H  = W / 2;
    localparam int ZW = 2 * H - 1;
    localparam int PW = 2 * W - 1;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [ZW-1:0]   z0;
    logic [ZW-1:0]   z2;

    logic [H-1:0]    mul_x;
    logic [H-1:0]    mul_y;
    logic [ZW-1:0]   mul_z;

    logic [REC_MAX-1:0] rec_full;
    logic [PW-1:0]      p_next;
    logic               rec_unused;

    // Operand mux for the single shared multiplier; the MID pass multiplies
    // the half-sums (a_lo^a_hi)*(b_lo^b_hi).
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            MUL_LO: begin
                mul_x = a_r[H-1:0];
                mul_y = b_r[H-1:0];
            end
            MUL_HI: begin
                mul_x = a_r[W-1:H];
                mul_y = b_r[W-1:H];
            end
            MUL_MID: begin
                mul_x = a_r[H-1:0] ^ a_r[W-1:H];
                mul_y = b_r[H-1:0] ^ b_r[W-1:H];
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    clmul16 #(.H(H)) u_mul (
        .x (mul_x),
        .y (mul_y),
        .z (mul_z)
    );

    // During MUL_MID mul_z is zm, so the full product is formed on that edge.
    assign rec_full   = kara_recombine(REC_MAX'(z0), REC_MAX'(mul_z), REC_MAX'(z2), H);
    assign p_next     = rec_full[PW-1:0];
    assign rec_unused = ^rec_full[REC_MAX-1:PW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            a_r       <= '0;
            b_r       <= '0;
            z0        <= '0;
            z2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        state    <= MUL_LO;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MUL_LO: begin
                    z0    <= mul_z;
                    state <= MUL_HI;
                end
                MUL_HI: begin
                    z2    <= mul_z;
                    state <= MUL_MID;
                end
                MUL_MID: begin
                    p         <= p_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
